// File: rtl/sol_core_control_if.sv
// Handshake/bus bundle between sol_core_control and the surrounding core.
// The master drives requests into the control unit; the slave is the control unit.
interface sol_core_control_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_IRQ = 8
);
   logic [NUM_IRQ-1:0] IrqLines;
   logic               RetireValid;
   logic [XLEN-1:0]    InstructionPointer;
   logic               CcrWriteEnable;
   logic [XLEN-1:0]    CcrWriteData;
   logic               ReturnReq;
   logic [XLEN-1:0]    CcrOut;
   logic               Mode;
   logic               Halt;
   logic               Redirect;
   logic [XLEN-1:0]    RedirectTarget;
   logic [XLEN-1:0]    SavedIP;
   logic [NUM_IRQ-1:0] IrqAck;

   modport master (
      output IrqLines, RetireValid, InstructionPointer, CcrWriteEnable, CcrWriteData, ReturnReq,
      input  CcrOut, Mode, Halt, Redirect, RedirectTarget, SavedIP, IrqAck
   );

   modport slave (
      input  IrqLines, RetireValid, InstructionPointer, CcrWriteEnable, CcrWriteData, ReturnReq,
      output CcrOut, Mode, Halt, Redirect, RedirectTarget, SavedIP, IrqAck
   );
endinterface

// File: rtl/sol_core_control.sv
// sol32 core control unit: CCR, privilege mode, banked return state,
// prioritised interrupt entry/return and halt/wake sequencing.
module sol_core_control #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     NUM_IRQ       = 8,
   parameter logic [XLEN-1:0] VECTOR_BASE   = 32'h0000_0100,
   parameter int unsigned     VECTOR_STRIDE = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   sol_core_control_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, ENTER = 2'd1, HALTED = 2'd2} state_t;

   state_t             state_r, state_s;
   logic               mode_r, mode_s, saved_mode_r, saved_mode_s, ie_r, ie_s;
   logic               priv_fault_r, priv_fault_s, halt_req_r, halt_req_s;
   logic               redirect_r, redirect_s;
   logic [NUM_IRQ-1:0] mask_r, mask_s, pending_r, pending_s, irq_prev_r, ack_r, ack_s;
   logic [XLEN-1:0]    saved_ip_r, saved_ip_s, target_r, target_s, ccr_s;
   logic [NUM_IRQ-1:0] eligible_s, onehot_s;
   logic [4:0]         idx_s;
   logic               wr_ok_s, ret_ok_s, fault_s, take_s;

   // Next-state, CCR update and redirect/ack pulse generation.
   always_comb begin
      eligible_s = pending_r & mask_r;
      idx_s      = 5'd0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         idx_s = eligible_s[i] ? 5'(i) : idx_s;
      end
      onehot_s = NUM_IRQ'(1'b1) << idx_s;

      // A supervisor CCR write or a legal return both hold off interrupt entry.
      wr_ok_s  = bus.CcrWriteEnable & ~mode_r;
      ret_ok_s = (state_r == RUN) & bus.RetireValid & bus.ReturnReq & ~mode_r;
      fault_s  = mode_r & (bus.CcrWriteEnable | (bus.RetireValid & bus.ReturnReq));
      take_s   = (state_r == RUN) & bus.RetireValid & ie_r & (|eligible_s) & ~ret_ok_s & ~wr_ok_s;

      state_s      = state_r;
      mode_s       = mode_r;
      saved_mode_s = saved_mode_r;
      ie_s         = ie_r;
      mask_s       = mask_r;
      priv_fault_s = priv_fault_r | fault_s;
      halt_req_s   = halt_req_r;
      saved_ip_s   = saved_ip_r;
      pending_s    = (pending_r & ~(take_s ? onehot_s : {NUM_IRQ{1'b0}})) | (bus.IrqLines & ~irq_prev_r);
      redirect_s   = 1'b0;
      target_s     = {XLEN{1'b0}};
      ack_s        = {NUM_IRQ{1'b0}};

      if (wr_ok_s) begin
         mode_s       = bus.CcrWriteData[31];
         saved_mode_s = bus.CcrWriteData[30];
         ie_s         = bus.CcrWriteData[29];
         mask_s       = bus.CcrWriteData[NUM_IRQ+7:8];
         priv_fault_s = bus.CcrWriteData[1];
         halt_req_s   = bus.CcrWriteData[0];
      end else begin
         mask_s = mask_r;
      end

      case (state_r)
         RUN: begin
            if (take_s) begin
               state_s      = ENTER;
               saved_ip_s   = bus.InstructionPointer;
               saved_mode_s = mode_r;
               mode_s       = 1'b0;
               ie_s         = 1'b0;
               redirect_s   = 1'b1;
               target_s     = VECTOR_BASE + XLEN'(idx_s) * XLEN'(VECTOR_STRIDE);
               ack_s        = onehot_s;
            end else if (ret_ok_s) begin
               redirect_s = 1'b1;
               target_s   = saved_ip_r;
               mode_s     = saved_mode_r;
               ie_s       = 1'b1;
            end else if (halt_req_r) begin
               state_s = HALTED;
            end else begin
               state_s = RUN;
            end
         end
         ENTER: begin
            state_s = RUN;
         end
         HALTED: begin
            // Wake does not depend on IE; the interrupt is taken later at a boundary.
            if (|eligible_s) begin
               state_s    = RUN;
               halt_req_s = 1'b0;
            end else begin
               state_s = HALTED;
            end
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // State and architectural registers; reset drops any pulse in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r      <= RUN;
         mode_r       <= 1'b0;
         saved_mode_r <= 1'b0;
         ie_r         <= 1'b0;
         mask_r       <= {NUM_IRQ{1'b0}};
         priv_fault_r <= 1'b0;
         halt_req_r   <= 1'b0;
         saved_ip_r   <= {XLEN{1'b0}};
         pending_r    <= {NUM_IRQ{1'b0}};
         irq_prev_r   <= {NUM_IRQ{1'b0}};
         redirect_r   <= 1'b0;
         target_r     <= {XLEN{1'b0}};
         ack_r        <= {NUM_IRQ{1'b0}};
      end else begin
         state_r      <= state_s;
         mode_r       <= mode_s;
         saved_mode_r <= saved_mode_s;
         ie_r         <= ie_s;
         mask_r       <= mask_s;
         priv_fault_r <= priv_fault_s;
         halt_req_r   <= halt_req_s;
         saved_ip_r   <= saved_ip_s;
         pending_r    <= pending_s;
         irq_prev_r   <= bus.IrqLines;
         redirect_r   <= redirect_s;
         target_r     <= target_s;
         ack_r        <= ack_s;
      end
   end

   // CCR image assembled from its field registers; unmapped bits read zero.
   always_comb begin
      ccr_s                = {XLEN{1'b0}};
      ccr_s[31]            = mode_r;
      ccr_s[30]            = saved_mode_r;
      ccr_s[29]            = ie_r;
      ccr_s[NUM_IRQ+7:8]   = mask_r;
      ccr_s[1]             = priv_fault_r;
      ccr_s[0]             = halt_req_r;
   end

   assign bus.CcrOut         = ccr_s;
   assign bus.Mode           = mode_r;
   assign bus.Halt           = (state_r == HALTED);
   assign bus.Redirect       = redirect_r;
   assign bus.RedirectTarget = target_r;
   assign bus.SavedIP        = saved_ip_r;
   assign bus.IrqAck         = ack_r;
endmodule
